// File: rtl/ecg_sample_uart_tx.sv
// Buffers 12-bit ADC samples in a FIFO and sends each one as a 2-byte 8N1 UART packet.
// Latency: dv -> tx falls 2 clocks later; no backpressure, full FIFO drops the sample and sets overflow.
module ecg_sample_uart_tx #(
  parameter int FCLK       = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [11:0]                   data,
  input  logic                          dv,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CLKS_PER_BIT = (FCLK + BAUD / 2) / BAUD;
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int CBW          = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]     FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [CBW-1:0]  BIT_LAST = CBW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [11:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [11:0]     hold;
  logic [7:0]      shift;
  logic [CBW-1:0]  baud_cnt;
  logic [2:0]      bit_idx;
  logic            byte_idx;
  logic            pop;
  logic            push;
  logic            bit_end;

  assign pop     = (state == IDLE) && (fifo_count != '0);
  assign push    = dv && ((fifo_count != FULL_CNT) || pop);
  assign bit_end = (baud_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
      if (dv && !push) overflow <= 1'b1;
    end
  end

  // tx/busy are registered from the current state, so every bit period keeps its exact length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      hold     <= '0;
      shift    <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= 1'b0;
    end else begin
      busy <= (state != IDLE);
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            hold     <= mem[rd_ptr];
            shift    <= {3'b100, mem[rd_ptr][11:7]};
            byte_idx <= 1'b0;
            baud_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          tx <= shift[bit_idx];
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            baud_cnt <= '0;
            if (!byte_idx) begin
              shift    <= {1'b0, hold[6:0]};
              byte_idx <= 1'b1;
              state    <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecg_sample_uart_tx.sv
// Bench for ecg_sample_uart_tx: a free-running UART receiver decodes tx, tasks compare against spec-derived bytes/timing.
module tb_ecg_sample_uart_tx;

  localparam int FCLK  = 100_000_000;
  localparam int BAUD  = 9_600_000;
  localparam int DEPTH = 16;
  localparam int CPB   = 10;          // round(100e6 / 9.6e6)
  localparam int PKT   = 20 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dv = 1'b0;
  logic [11:0] data = '0;
  logic        tx, busy, overflow;
  logic [4:0]  fifo_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int dv_cyc   = 0;
  int peak     = 0;
  int frame_err = 0;
  logic [7:0] rx_q[$];
  int         fall_q[$];

  ecg_sample_uart_tx #(.FCLK(FCLK), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data(data), .dv(dv),
    .tx(tx), .busy(busy), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- reference model helpers ----------------
  function automatic logic [7:0] b0(input logic [11:0] d);
    return {3'b100, d[11:7]};
  endfunction

  function automatic logic [7:0] b1(input logic [11:0] d);
    return {1'b0, d[6:0]};
  endfunction

  // Expected line level during bit period k (0..19) of the packet for sample d.
  function automatic logic frame_bit(input logic [11:0] d, input int k);
    logic [7:0] b;
    int p;
    b = (k < 10) ? b0(d) : b1(d);
    p = k % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return b[p-1];
  endfunction

  function automatic logic [7:0] rx_at(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 8'hxx;
  endfunction

  function automatic int fall_at(input int i);
    if (i < fall_q.size()) return fall_q[i];
    return -1;
  endfunction

  // ---------------- UART receiver (mid-bit sampling) ----------------
  task automatic mon_wait(input int n, inout logic ab);
    repeat (n) begin
      @(negedge clk);
      if (rst) ab = 1'b1;
    end
  endtask

  always begin : rx_monitor
    logic [7:0] b;
    logic ok, ab;
    int t;
    @(negedge clk);
    if (!rst && tx === 1'b0) begin
      t = cyc; ok = 1'b1; ab = 1'b0; b = '0;
      mon_wait(CPB / 2, ab);
      if (tx !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        mon_wait(CPB, ab);
        b[i] = tx;
      end
      mon_wait(CPB, ab);
      if (tx !== 1'b1) ok = 1'b0;
      if (!ab) begin
        if (ok) begin
          rx_q.push_back(b);
          fall_q.push_back(t);
        end else begin
          frame_err++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic note_peak();
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
  endtask

  task automatic pulse(input logic [11:0] d);
    @(negedge clk); data = d; dv = 1'b1; note_peak();
    @(negedge clk); dv = 1'b0; dv_cyc = cyc; note_peak();
  endtask

  task automatic wait_rx(input int target, input int budget);
    for (int i = 0; i < budget && !(rx_q.size() >= target && !busy); i++) begin
      @(negedge clk);
      note_peak();
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    data = 12'hABC; dv = 1'b1;
    @(negedge clk); dv = 1'b0;
    @(negedge clk);
    n_checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
    n_checks++; if (fifo_count !== 5'd0) $display("FAIL reset_count: got %0d want 0", fifo_count); else n_pass++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (fifo_count !== 5'd0 || tx !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_dv_ignored: count=%0d tx=%b busy=%b want 0/1/0", fifo_count, tx, busy);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [11:0] d;
    int tx_err, busy_err, base, fbase, k0;
    logic et, eb;
    d = 12'h7DC; tx_err = 0; busy_err = 0;
    base = rx_q.size(); fbase = fall_q.size();
    @(negedge clk); data = d; dv = 1'b1;
    @(negedge clk); dv = 1'b0; k0 = cyc;
    for (int k = 1; k <= PKT + 6; k++) begin
      @(negedge clk);
      eb = (k >= 2) && (k < 2 + PKT);
      et = eb ? frame_bit(d, (k - 2) / CPB) : 1'b1;
      if (tx !== et) tx_err++;
      if (busy !== eb) busy_err++;
    end
    wait_rx(base + 2, 4 * CPB);
    n_checks++; if (tx_err != 0) $display("FAIL single_tx_wave: %0d bad cycles want 0", tx_err); else n_pass++;
    n_checks++; if (busy_err != 0) $display("FAIL single_busy_wave: %0d bad cycles want 0", busy_err); else n_pass++;
    n_checks++; if (fall_at(fbase) - k0 != 2) $display("FAIL single_latency: got %0d want 2", fall_at(fbase) - k0); else n_pass++;
    n_checks++; if (rx_at(base) !== 8'h8F) $display("FAIL single_byte0: got %h want 8f", rx_at(base)); else n_pass++;
    n_checks++; if (rx_at(base + 1) !== 8'h5C) $display("FAIL single_byte1: got %h want 5c", rx_at(base + 1)); else n_pass++;
  endtask

  task automatic test_boundary();
    int base, fbase, errs;
    logic [7:0] exp_b[$];
    base = rx_q.size(); fbase = fall_q.size(); peak = 0; errs = 0;
    exp_b = '{8'h80, 8'h00, 8'h9F, 8'h7F};
    pulse(12'h000);
    pulse(12'hFFF);
    wait_rx(base + 4, 3 * PKT);
    n_checks++; if (rx_q.size() != base + 4) $display("FAIL boundary_count: got %0d bytes want 4", rx_q.size() - base); else n_pass++;
    for (int i = 0; i < 4; i++) if (rx_at(base + i) !== exp_b[i]) errs++;
    n_checks++; if (errs != 0) $display("FAIL boundary_bytes: %0d wrong bytes want 0", errs); else n_pass++;
    n_checks++;
    if (fall_at(fbase + 2) - fall_at(fbase) != PKT + 1)
      $display("FAIL boundary_gap: got %0d cycles want %0d", fall_at(fbase + 2) - fall_at(fbase), PKT + 1);
    else n_pass++;
    n_checks++; if (peak != 1) $display("FAIL boundary_peak: got %0d want 1", peak); else n_pass++;
  endtask

  task automatic test_overflow();
    int base, errs;
    base = rx_q.size(); peak = 0; errs = 0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk); data = 12'(i); dv = 1'b1; note_peak();
    end
    @(negedge clk); dv = 1'b0; note_peak();
    n_checks++; if (peak != 16) $display("FAIL ovf_peak: got %0d want 16", peak); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow); else n_pass++;
    wait_rx(base + 34, 18 * (PKT + 1) + 100);
    n_checks++; if (rx_q.size() != base + 34) $display("FAIL ovf_bytes: got %0d want 34", rx_q.size() - base); else n_pass++;
    for (int s = 1; s <= 17; s++) begin
      if (rx_at(base + 2 * (s - 1)) !== b0(12'(s))) errs++;
      if (rx_at(base + 2 * (s - 1) + 1) !== b1(12'(s))) errs++;
    end
    n_checks++; if (errs != 0) $display("FAIL ovf_data: %0d wrong bytes want 0", errs); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else n_pass++;
  endtask

  task automatic test_simul_push_pop();
    int base, fbase, ta, errs;
    logic [11:0] d;
    logic [11:0] exp_s[$];
    do_reset();
    n_checks++; if (overflow !== 1'b0) $display("FAIL simul_ovf_cleared: got %b want 0", overflow); else n_pass++;
    base = rx_q.size(); fbase = fall_q.size(); errs = 0;
    d = 12'($urandom); exp_s.push_back(d);
    pulse(d); ta = dv_cyc;
    for (int i = 0; i < 16; i++) begin
      d = 12'($urandom); exp_s.push_back(d);
      @(negedge clk); data = d; dv = 1'b1;
    end
    @(negedge clk); dv = 1'b0;
    n_checks++; if (fifo_count !== 5'd16) $display("FAIL simul_full: got %0d want 16", fifo_count); else n_pass++;
    // The next pop edge is one bit-period-packet after tx first fell (ta+2).
    while (cyc < ta + 1 + PKT) @(negedge clk);
    d = 12'($urandom); exp_s.push_back(d);
    data = d; dv = 1'b1;
    @(negedge clk); dv = 1'b0;
    n_checks++; if (fifo_count !== 5'd16) $display("FAIL simul_count: got %0d want 16", fifo_count); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL simul_ovf: got %b want 0", overflow); else n_pass++;
    wait_rx(base + 36, 19 * (PKT + 1) + 100);
    n_checks++;
    if (fall_at(fbase + 2) != ta + PKT + 3)
      $display("FAIL simul_pop_timing: second packet at %0d want %0d", fall_at(fbase + 2), ta + PKT + 3);
    else n_pass++;
    for (int i = 0; i < 18; i++) begin
      if (rx_at(base + 2 * i) !== b0(exp_s[i])) errs++;
      if (rx_at(base + 2 * i + 1) !== b1(exp_s[i])) errs++;
    end
    n_checks++; if (errs != 0) $display("FAIL simul_data: %0d wrong bytes want 0", errs); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int ta, base, fbase;
    logic [11:0] x;
    x = 12'($urandom);
    pulse(x); ta = dv_cyc;
    pulse(12'($urandom));
    pulse(12'($urandom));
    // Middle of data bit 3 of byte0 (bit period 4 of the packet).
    while (cyc < ta + 2 + 4 * CPB + CPB / 2) @(negedge clk);
    n_checks++; if (tx !== frame_bit(x, 4)) $display("FAIL mid_bit3: got %b want %b", tx, frame_bit(x, 4)); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 5'd0)
      $display("FAIL mid_reset_async: tx=%b busy=%b count=%0d want 1/0/0", tx, busy, fifo_count);
    else n_pass++;
    @(negedge clk); data = 12'h555; dv = 1'b1;
    @(negedge clk); dv = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (10 * CPB) @(negedge clk);
    n_checks++;
    if (tx !== 1'b1 || fifo_count !== 5'd0) $display("FAIL mid_quiet: tx=%b count=%0d want 1/0", tx, fifo_count);
    else n_pass++;
    base = rx_q.size(); fbase = fall_q.size();
    pulse(12'h123);
    wait_rx(base + 2, 2 * PKT);
    n_checks++; if (rx_q.size() != base + 2) $display("FAIL mid_count: got %0d bytes want 2", rx_q.size() - base); else n_pass++;
    n_checks++; if (rx_at(base) !== 8'h82) $display("FAIL mid_byte0: got %h want 82", rx_at(base)); else n_pass++;
    n_checks++; if (rx_at(base + 1) !== 8'h23) $display("FAIL mid_byte1: got %h want 23", rx_at(base + 1)); else n_pass++;
    n_checks++; if (fall_at(fbase) - dv_cyc != 2) $display("FAIL mid_latency: got %0d want 2", fall_at(fbase) - dv_cyc); else n_pass++;
  endtask

  task automatic test_stream();
    int base, errs, ferr0;
    logic [11:0] d;
    logic [11:0] exp_s[$];
    base = rx_q.size(); errs = 0; peak = 0; ferr0 = frame_err;
    for (int s = 0; s < 50; s++) begin
      d = 12'($urandom); exp_s.push_back(d);
      pulse(d);
      repeat (PKT + int'($urandom_range(2, 150))) begin @(negedge clk); note_peak(); end
    end
    wait_rx(base + 100, 2 * PKT);
    n_checks++; if (rx_q.size() != base + 100) $display("FAIL stream_count: got %0d bytes want 100", rx_q.size() - base); else n_pass++;
    for (int i = 0; i < 50; i++) begin
      if (rx_at(base + 2 * i) !== b0(exp_s[i])) errs++;
      if (rx_at(base + 2 * i + 1) !== b1(exp_s[i])) errs++;
    end
    n_checks++; if (errs != 0) $display("FAIL stream_data: %0d wrong bytes want 0", errs); else n_pass++;
    n_checks++; if (peak > 1) $display("FAIL stream_peak: got %0d want <=1", peak); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL stream_ovf: got %b want 0", overflow); else n_pass++;
    n_checks++; if (frame_err != ferr0) $display("FAIL stream_framing: got %0d errors want 0", frame_err - ferr0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_overflow();
    test_simul_push_pop();
    test_reset_midframe();
    test_stream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
